timer_irq_src: RTL and testbench
================================

# timer_irq_src

Memory-mapped countdown timer and interrupt source on the CPU's peripheral bus. Software programs it through store/load accesses, and on expiry it drives `IRQ` into one bit of the coprocessor's `HWint[5:0]` vector. It supports one-shot and auto-reload modes. Its interrupt is level (sticky) or pulse depending on mode, and software clears it through a register write.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr` in 2: word offset, `addr[1:0]` = byte address bits [3:2]. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we` in 1: write strobe, one word per cycle.
- `wdata` in 32: write data.
- `rdata` out 32: read data, combinational from `addr`.
- `IRQ` out 1: interrupt request to `HWint`.

## Operation
- CTRL fields:
  - [0] EN (enable).
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as 00.
  - [3] IM (interrupt mask, 1 = allow).
  - [31:4] are write-ignored and read as 0.
- PRESET: 32-bit reload value, read/write.
- COUNT: 32-bit current value, read-only; writes are ignored.
- Reserved offset reads as 0 and ignores writes.
- `IRQ = irq_flag & CTRL.IM`.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN → LOAD.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT:
    - if !EN → IDLE, COUNT holds.
    - else if COUNT > 1 → COUNT − 1, stay in CNT.
    - else (COUNT ≤ 1) → COUNT ← 0, → INT.
  - INT: irq_flag ← 1.
    - MODE 00: EN ← 0, → IDLE.
    - MODE 01: → LOAD.
- irq_flag clearing:
  - MODE 00: irq_flag stays 1 until a write to CTRL or PRESET.
  - MODE 01: irq_flag is cleared the cycle after INT, giving a 1-cycle pulse.
- Any write to CTRL or PRESET:
  - forces the next state to IDLE and clears irq_flag;
  - the written value takes effect at the same edge;
  - it overrides the FSM update of that cycle, including the EN ← 0 in INT.
- PRESET = 0 behaves like PRESET = 1: one CNT cycle, then INT.
- Arithmetic is unsigned 32-bit. COUNT never wraps below 0.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, irq_flag = 0, `IRQ` = 0. `rdata` then reflects these registers.
- Reset mid-count: returns to all reset values at the next edge. No IRQ is generated.
- Write in cycle c0 with EN = 1:
  - IDLE in c1, LOAD in c2, CNT in c3 … c(2+N), INT in c(3+N).
  - `IRQ` high from c(4+N), if IM = 1.
  - N = max(PRESET, 1).
- Auto-reload period is N+2 cycles (INT, LOAD, N×CNT). `IRQ` is high exactly 1 cycle per period.
- `rdata` has zero-cycle latency. A read in the same cycle as a write returns the old value.
- IM toggles `IRQ` combinationally and does not alter irq_flag. Clearing IM and later setting it again re-exposes a pending one-shot flag only if no CTRL write cleared it. Since every CTRL write clears the flag, a pending flag is in practice dropped.

## Configuration
- Macro: `TIMER_AUTORELOAD_EN`.
- Defined: MODE 01 behaves as auto-reload, as above.
- Undefined: MODE 01 is treated as 00 (one-shot, sticky flag, EN cleared). The MODE field still reads back as written.

## Test plan
- Reset, then read all offsets:
  - `rdata` = 0 for CTRL, PRESET, COUNT and reserved; `IRQ` = 0.
- One-shot:
  - Stimulus: PRESET = 5; CTRL = 0x9 written in c0.
  - Response: COUNT reads 5, 4, 3, 2, 1 in c3–c7 and 0 from c8. `IRQ` rises in c9 and stays high. CTRL reads 0x8.
  - Then write PRESET = 5: `IRQ` = 0 the next cycle.
- Auto-reload (macro defined):
  - Stimulus: PRESET = 3, CTRL = 0xB.
  - Response: `IRQ` single-cycle pulses 5 cycles apart, over at least 3 periods.
  - Same stimulus with macro undefined: one pulse, then sticky high, EN = 0.
- Masking:
  - Stimulus: PRESET = 2, CTRL = 0x1 (IM = 0).
  - Response: `IRQ` stays 0 throughout; CTRL = 0x0 after expiry.
- Stop mid-count:
  - Stimulus: PRESET = 10, CTRL = 0x9; in the 4th CNT cycle write CTRL = 0x8.
  - Response: COUNT holds at 7, no `IRQ`. Writing COUNT = 0xFFFF has no effect.
- PRESET = 0 with CTRL = 0x9:
  - Response: `IRQ` rises 5 cycles after the write. Also check that `rst` asserted during CNT returns all registers to 0 on the next edge.

Source files
------------

// File: rtl/timer_irq_src.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_src
// Brief    : Memory-mapped countdown timer and interrupt source. Supports
//            one-shot and auto-reload modes (auto-reload needs the
//            TIMER_AUTORELOAD_EN macro).
// Revision : 1.0 - initial release
// ============================================================================
module timer_irq_src (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        IRQ
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_CNT  = 2'd2;
    localparam logic [1:0] c_ST_INT  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        w_autoreload;
    logic        w_wr_ctrl;
    logic        w_wr_preset;

`ifdef TIMER_AUTORELOAD_EN
    assign w_autoreload = (mode_q == 2'b01);
`else
    assign w_autoreload = 1'b0;
`endif

    assign w_wr_ctrl   = we && (addr == 2'd0);
    assign w_wr_preset = we && (addr == 2'd1);

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            c_ST_IDLE: begin
                if (en_q) begin
                    state_d = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                count_d = preset_q;
                state_d = c_ST_CNT;
            end
            c_ST_CNT: begin
                if (!en_q) begin
                    state_d = c_ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    state_d = c_ST_INT;
                end
            end
            default: begin
                irq_flag_d = 1'b1;
                if (w_autoreload) begin
                    state_d = c_ST_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = c_ST_IDLE;
                end
            end
        endcase

        // Auto-reload flag lives only for the cycle following INT.
        if (w_autoreload && (state_q != c_ST_INT)) begin
            irq_flag_d = 1'b0;
        end

        // A register write discards this cycle's FSM update entirely.
        if (w_wr_ctrl || w_wr_preset) begin
            state_d    = c_ST_IDLE;
            irq_flag_d = 1'b0;
            count_d    = count_q;
            en_d       = en_q;
            if (w_wr_ctrl) begin
                en_d   = wdata[0];
                mode_d = wdata[2:1];
                im_d   = wdata[3];
            end
            if (w_wr_preset) begin
                preset_d = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_ST_IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {28'd0, im_q, mode_q, en_q};
            2'd1:    rdata = preset_q;
            2'd2:    rdata = count_q;
            default: rdata = 32'd0;
        endcase
    end

    assign IRQ = irq_flag_q & im_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_irq_src
// Brief    : Bench for timer_irq_src; expected values come from a timeline
//            model (cycles elapsed since the last CTRL/PRESET write).
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_irq_src;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: programmed registers, count frozen at the last write, and k =
    // number of edges elapsed since that write.
    logic [31:0] m_preset;
    logic [31:0] m_cnt0;
    logic        m_en;
    logic        m_im;
    logic [1:0]  m_mode;
    longint      m_k;

    timer_irq_src dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    function automatic bit m_auto();
`ifdef TIMER_AUTORELOAD_EN
        return (m_mode == 2'b01);
`else
        return 1'b0;
`endif
    endfunction

    function automatic longint m_n();
        return (m_preset == 32'd0) ? 64'd1 : longint'(m_preset);
    endfunction

    function automatic logic [31:0] m_count();
        longint j;
        longint ph;
        if (!m_en || m_k < 3) return m_cnt0;
        j = m_k - 3;
        if (m_auto()) begin
            ph = j % (m_n() + 2);
            return (ph < m_n()) ? m_preset - 32'(ph) : 32'd0;
        end
        return (j < m_n()) ? m_preset - 32'(j) : 32'd0;
    endfunction

    function automatic bit m_en_eff();
        return m_en && !(!m_auto() && (m_k >= 4 + m_n()));
    endfunction

    function automatic bit m_irq();
        if (!m_en || !m_im || (m_k < 4 + m_n())) return 1'b0;
        if (m_auto()) return ((m_k - 3) % (m_n() + 2)) == (m_n() + 1);
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en_eff()};
            2'd1:    return m_preset;
            2'd2:    return m_count();
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h k=%0d", tag, obs, exp, m_k);
        end
    endtask

    // One bus cycle: drive, check this cycle's outputs, clock, advance model.
    task automatic step(input bit w, input logic [1:0] a, input logic [31:0] d, input bit r);
        rst   = r;
        we    = w;
        addr  = a;
        wdata = d;
        #1;
        check($sformatf("rdata[%0d]", a), rdata, m_rdata(a));
        check("irq", {31'd0, IRQ}, {31'd0, m_irq()});
        @(posedge clk);
        #1;
        if (r) begin
            m_preset = 32'd0;
            m_cnt0   = 32'd0;
            m_en     = 1'b0;
            m_im     = 1'b0;
            m_mode   = 2'b00;
            m_k      = 0;
        end else if (w && (a <= 2'd1)) begin
            m_cnt0 = m_count();
            if (a == 2'd0) begin
                {m_im, m_mode, m_en} = d[3:0];
            end else begin
                m_en     = m_en_eff();
                m_preset = d;
            end
            m_k = 1;
        end else begin
            m_k++;
        end
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b0, a, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0);
    endtask

    initial begin
        m_preset = '0; m_cnt0 = '0; m_en = 0; m_im = 0; m_mode = '0; m_k = 0;
        rst = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        @(posedge clk);
        #1;
        step(1'b0, 2'd0, 32'd0, 1'b1);
        for (int a = 0; a < 4; a++) rd(2'(a));

        // One-shot, then clear via PRESET write
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        repeat (12) rd(2'd2);
        rd(2'd0);
        wr(2'd1, 32'd5);
        rd(2'd0);

        // Auto-reload (or one-shot when the macro is off)
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        repeat (22) rd(2'($urandom_range(0, 3)));

        // Masked expiry
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        repeat (10) rd(2'($urandom_range(0, 2)));

        // Stop in the 4th CNT cycle, then try to write COUNT
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        repeat (5) rd(2'd2);
        wr(2'd0, 32'h8);
        wr(2'd2, 32'hFFFF);
        repeat (5) rd(2'd2);

        // PRESET = 0
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        repeat (8) rd(2'd2);

        // Reset during CNT
        wr(2'd1, 32'd9);
        wr(2'd0, 32'h9);
        repeat (4) rd(2'd2);
        step(1'b0, 2'd2, 32'd0, 1'b1);
        for (int a = 0; a < 4; a++) rd(2'(a));

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                wr(2'd1, ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 7)));
            end else if (r < 4) begin
                wr(2'd0, $urandom);
            end else if (r < 6) begin
                wr(2'($urandom_range(2, 3)), $urandom);
            end else if (r == 6) begin
                step(1'b0, 2'($urandom_range(0, 3)), 32'd0, 1'b1);
            end else begin
                rd(2'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
